// File: rtl/rf_dualwr_scoreboard.sv
// Dual-read / dual-write register file with sync clear, optional write bypass
// and a per-register busy scoreboard for decode-stage hazard detection.

module rf_dualwr_cell #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss,
  input  logic [ADDR_W-1:0] ia,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              busy_nxt
);
  localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(IDX);

  logic [DATA_W-1:0] data_d, data_q;
  logic              busy_d, busy_q;
  logic              hit0, hit1;

  always_comb begin
    hit0   = we0 && (wa0 == MY_ADDR);
    hit1   = we1 && (wa1 == MY_ADDR);
    data_d = data_q;
    if (hit0)      data_d = wd0;
    else if (hit1) data_d = wd1;
    // A fresh issue supersedes any older producer retiring this cycle.
    busy_d = busy_q;
    if (iss && (ia == MY_ADDR)) busy_d = 1'b1;
    else if (hit0 || hit1)      busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data     = data_q;
  assign busy     = busy_q;
  assign busy_nxt = busy_d;
endmodule

module rf_dualwr_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  output logic [DATA_W-1:0] Bus_A,
  output logic [DATA_W-1:0] Bus_B,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              wr_conflict,
  output logic [ADDR_W:0]   busy_count
);
  localparam int NREGS = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             busy, busy_d;
  logic                         we0_eff, we1_eff, iss_eff;
  logic                         byp0_a, byp1_a, byp0_b, byp1_b;
  logic                         wr_conflict_d, wr_conflict_q;
  logic [ADDR_W:0]              busy_count_d, busy_count_q;

  // R0 is filtered here so its cell never sees a write or an issue.
  always_comb begin
    we0_eff = wr0_en   && !(ZR && (wr0_addr   == '0));
    we1_eff = wr1_en   && !(ZR && (wr1_addr   == '0));
    iss_eff = issue_en && !(ZR && (issue_addr == '0));
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    rf_dualwr_cell #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX(r)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .we0     (we0_eff),
      .wa0     (wr0_addr),
      .wd0     (wr0_data),
      .we1     (we1_eff),
      .wa1     (wr1_addr),
      .wd1     (wr1_data),
      .iss     (iss_eff),
      .ia      (issue_addr),
      .data    (regs[r]),
      .busy    (busy[r]),
      .busy_nxt(busy_d[r])
    );
  end

  always_comb begin
    byp0_a = BP && we0_eff && (wr0_addr == Rs1);
    byp1_a = BP && we1_eff && (wr1_addr == Rs1);
    byp0_b = BP && we0_eff && (wr0_addr == Rs2);
    byp1_b = BP && we1_eff && (wr1_addr == Rs2);

    Bus_A = regs[Rs1];
    if (byp0_a)      Bus_A = wr0_data;
    else if (byp1_a) Bus_A = wr1_data;
    Bus_B = regs[Rs2];
    if (byp0_b)      Bus_B = wr0_data;
    else if (byp1_b) Bus_B = wr1_data;

    // A producer writing back this cycle no longer blocks a bypassed read.
    busy_a = busy[Rs1] && !(byp0_a || byp1_a);
    busy_b = busy[Rs2] && !(byp0_b || byp1_b);

    if (ZR && (Rs1 == '0)) begin
      Bus_A  = '0;
      busy_a = 1'b0;
    end
    if (ZR && (Rs2 == '0)) begin
      Bus_B  = '0;
      busy_b = 1'b0;
    end
  end

  always_comb begin
    wr_conflict_d = we0_eff && we1_eff && (wr0_addr == wr1_addr);
    busy_count_d  = '0;
    for (int i = 0; i < NREGS; i++)
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_conflict_q <= 1'b0;
      busy_count_q  <= '0;
    end else begin
      wr_conflict_q <= wr_conflict_d;
      busy_count_q  <= busy_count_d;
    end
  end

  assign wr_conflict = wr_conflict_q;
  assign busy_count  = busy_count_q;
endmodule
